// File: rtl/icache_prefetch_buffer.sv
// icache_prefetch_buffer
//
// Sits between the instruction cache's line-fill port and main memory.
// Demand misses are forwarded to memory. After each served line, the block
// speculatively fetches the next sequential line into a one-entry stream
// buffer. A later demand for that buffered line is answered one cycle after
// the request, with no memory access. A demand that arrives while the
// prefetch of that same line is still in flight merges with it, so the
// line is not read twice.
//
// Ports
//   clk         clock
//   proc_reset  asynchronous active-high reset
//   c_read      cache read request, held with stable c_addr until c_ready
//   c_write     cache write request, ignored (instruction side is read-only)
//   c_addr      requested line address [ADDR_W]
//   c_rdata     returned line [LINE_W], valid while c_ready=1 (registered)
//   c_ready     one-cycle completion pulse to the cache (registered)
//   mem_read    memory read request, drops in the mem_ready cycle
//   mem_write   always 0
//   mem_addr    memory line address [ADDR_W] (registered, stable per transaction)
//   mem_wdata   always 0
//   mem_rdata   memory line data [LINE_W], valid while mem_ready=1
//   mem_ready   one-cycle memory completion pulse

module icache_prefetch_buffer #(
  parameter bit PREFETCH_EN = 1'b1,
  parameter int ADDR_W      = 28,
  parameter int LINE_W      = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    RESP     = 2'd2,
    PREFETCH = 2'd3
  } state_t;

  state_t state, state_d;

  // Stream buffer entry.
  logic              pf_valid, pf_valid_d;
  logic [ADDR_W-1:0] pf_addr,  pf_addr_d;
  logic [LINE_W-1:0] pf_data,  pf_data_d;

  // Demand address, next prefetch target and demand-merged-into-prefetch flag.
  logic [ADDR_W-1:0] req_addr, req_addr_d;
  logic [ADDR_W-1:0] nxt_addr, nxt_addr_d;
  logic              merged,   merged_d;

  // Registered outputs.
  logic [LINE_W-1:0] c_rdata_d;
  logic              c_ready_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic buf_hit;
  logic pf_match;

  assign buf_hit  = c_read && pf_valid && (c_addr == pf_addr);
  assign pf_match = c_read && (c_addr == nxt_addr);

  // The read request drops combinationally in the completion cycle so the
  // memory never sees a second request for the same line.
  assign mem_read  = ((state == FETCH) || (state == PREFETCH)) && !mem_ready;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  // The instruction side never writes; the request is accepted and dropped.
  logic unused_c_write;
  assign unused_c_write = c_write;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    pf_valid_d = pf_valid;
    pf_addr_d  = pf_addr;
    pf_data_d  = pf_data;
    req_addr_d = req_addr;
    nxt_addr_d = nxt_addr;
    merged_d   = merged;
    c_rdata_d  = c_rdata;
    c_ready_d  = 1'b0;
    mem_addr_d = '0;

    case (state)
      IDLE: begin
        if (buf_hit) begin
          // Buffered line is consumed; the next prefetch follows it.
          c_rdata_d  = pf_data;
          pf_valid_d = 1'b0;
          nxt_addr_d = c_addr + ADDR_W'(1);
          state_d    = RESP;
        end else if (c_read) begin
          req_addr_d = c_addr;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        if (mem_ready) begin
          c_rdata_d  = mem_rdata;
          nxt_addr_d = req_addr + ADDR_W'(1);
          state_d    = RESP;
        end
      end

      RESP: begin
        state_d = PREFETCH_EN ? PREFETCH : IDLE;
      end

      PREFETCH: begin
        // A demand for the line being prefetched is remembered, including one
        // that only shows up in the completion cycle itself.
        merged_d = merged || pf_match;
        if (mem_ready) begin
          if (merged || pf_match) begin
            c_rdata_d  = mem_rdata;
            merged_d   = 1'b0;
            nxt_addr_d = nxt_addr + ADDR_W'(1);
            state_d    = RESP;
          end else begin
            // Park the line; any other pending demand is handled from IDLE.
            pf_data_d  = mem_rdata;
            pf_addr_d  = nxt_addr;
            pf_valid_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs are derived from the state being entered, so they
    // are valid from the first cycle of that state.
    c_ready_d = (state_d == RESP);

    if (state_d == FETCH) begin
      mem_addr_d = req_addr_d;
    end else if (state_d == PREFETCH) begin
      mem_addr_d = nxt_addr_d;
      // The old entry is stale once a new prefetch is in flight.
      pf_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: the line-wide data registers are reset along with the control bits;
  // they are plain flops, not a memory array, so the reset is cheap and keeps
  // c_rdata at a known value out of reset.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      pf_valid <= 1'b0;
      pf_addr  <= '0;
      pf_data  <= '0;
      req_addr <= '0;
      nxt_addr <= '0;
      merged   <= 1'b0;
      c_rdata  <= '0;
      c_ready  <= 1'b0;
      mem_addr <= '0;
    end else begin
      pf_valid <= pf_valid_d;
      pf_addr  <= pf_addr_d;
      pf_data  <= pf_data_d;
      req_addr <= req_addr_d;
      nxt_addr <= nxt_addr_d;
      merged   <= merged_d;
      c_rdata  <= c_rdata_d;
      c_ready  <= c_ready_d;
      mem_addr <= mem_addr_d;
    end
  end

endmodule

// File: doc/icache_prefetch_buffer.md
Name: icache_prefetch_buffer

Overview:
- Sits between the instruction cache's memory port and main memory.
- Forwards demand line fetches (128-bit lines, 28-bit line address) to memory. After each one it speculatively fetches the next sequential line into a one-entry stream buffer.
- A later cache miss to the buffered line is served in 1 cycle without a memory access, which cuts sequential-fetch stall time.

Parameters:
- PREFETCH_EN, 1, 1 = issue next-line prefetch after each served request; 0 = pure pass-through buffer (buffer never filled).
- ADDR_W, 28, line address width.
- LINE_W, 128, line data width.

Ports:
- clk  input  1  clock.
- proc_reset  input  1  reset, asynchronous, active-high.
- c_read  input  1  cache read request; held high with stable c_addr until c_ready.
- c_write  input  1  cache write request; ignored (instruction side is read-only).
- c_addr  input  ADDR_W  requested line address.
- c_rdata  output  LINE_W  returned line, valid while c_ready=1.
- c_ready  output  1  one-cycle completion pulse to cache.
- mem_read  output  1  memory read request.
- mem_write  output  1  held 0.
- mem_addr  output  ADDR_W  memory line address.
- mem_wdata  output  LINE_W  held 0.
- mem_rdata  input  LINE_W  memory line data, valid while mem_ready=1.
- mem_ready  input  1  one-cycle memory completion pulse.

Behaviour:
- Storage:
  - pf_valid, pf_addr[ADDR_W], pf_data[LINE_W].
  - req_addr register (demand address).
  - nxt_addr register (prefetch target).
  - merged flag.
- Reset (asynchronous, proc_reset=1), effective immediately:
  - state=IDLE; pf_valid=0, merged=0.
  - c_ready=0, c_rdata=0, mem_read=0, mem_addr=0.
  - Any in-flight memory read is abandoned. mem_rdata/mem_ready arriving later are ignored unless in FETCH/PREFETCH.
- Output timing:
  - c_ready and c_rdata are registered.
  - mem_read = (state==FETCH or PREFETCH) and not mem_ready, so it drops in the mem_ready cycle.
  - mem_addr is registered and stable for the whole transaction.
  - mem_addr=req_addr in FETCH, nxt_addr in PREFETCH, 0 otherwise.
- States:
  - IDLE:
    - If c_read, pf_valid and c_addr==pf_addr (buffer hit): latch pf_data into c_rdata, clear pf_valid, nxt_addr<=c_addr+1, go to RESP.
    - Else if c_read (miss): req_addr<=c_addr, go to FETCH.
    - Else stay.
  - FETCH:
    - Hold mem_read.
    - On mem_ready: c_rdata<=mem_rdata, nxt_addr<=req_addr+1, go to RESP.
  - RESP:
    - c_ready=1 for exactly this cycle; c_read is ignored here.
    - Next state is PREFETCH if PREFETCH_EN, else IDLE.
  - PREFETCH:
    - Hold mem_read on nxt_addr.
    - Any cycle where c_read=1 and c_addr==nxt_addr sets merged=1.
    - On mem_ready with merged (including a matching c_read in the mem_ready cycle itself): c_rdata<=mem_rdata, clear merged, pf_valid stays 0, nxt_addr<=nxt_addr+1, go to RESP.
    - On mem_ready without merge: pf_data<=mem_rdata, pf_addr<=nxt_addr, pf_valid<=1, go to IDLE. A pending non-matching c_read is then handled in IDLE as a miss.
    - An in-flight prefetch is never aborted; a non-matching demand waits for it.
- Arithmetic: nxt_addr increments modulo 2^ADDR_W; 0xFFFFFFF+1 = 0x0000000.
- Latency, with T = first cycle c_read is high in IDLE:
  - Buffer hit: c_ready at T+1.
  - Miss: mem_read from T+1; mem_ready at cycle M; c_ready at M+1.
- Buffer lifetime: a buffer hit consumes the entry. pf_valid=0 whenever a new prefetch is in flight.
- c_write=1 has no effect. mem_write and mem_wdata are always 0.

Test Plan:
- Reset then miss, memory latency 4: c_read=1, c_addr=0x0000010, mem_ready at T+4 with data D0 -> c_ready=1 at T+5 with c_rdata=D0. mem_read=1 on mem_addr=0x0000011 from T+6; after fill, pf_valid=1, pf_addr=0x0000011.
- Buffer hit: after the previous case, c_addr=0x0000011 -> c_ready exactly 1 cycle later with the prefetched data, no mem_read for 0x11. Then a prefetch of 0x0000012 starts.
- Merge: c_read c_addr=0x0000012 arrives 1 cycle into the prefetch of 0x12 -> no second memory read; c_ready the cycle after mem_ready with that data, then a prefetch of 0x13.
- Conflict: during prefetch of 0x13, c_read c_addr=0x0000200 -> prefetch completes (pf_addr=0x13 stored), then FETCH with mem_addr=0x0000200. c_ready follows that mem_ready by 1 cycle.
- Wrap: miss on 0xFFFFFFF -> next prefetch mem_addr=0x0000000.
- Async reset mid-FETCH: assert proc_reset between clock edges -> mem_read, c_ready and pf_valid are 0 immediately. A late mem_ready is ignored and the next c_read starts a fresh miss.
